// File: rtl/debounce_edge_ctrl.sv
// Debounce and edge control for one asynchronous level input.
// A two-flop synchronizer feeds a four-state qualification FSM. A new level is
// accepted only after STABLE_CYCLES consecutive identical synchronized samples.
// data_out, rise and fall are registered. enable_out marks the single cycle in
// which data_out carries a newly accepted value, so a downstream enable-gated
// register captures each accepted change exactly once.
// state_dbg exposes the FSM state for checkers.
`timescale 1ns/1ps
module debounce_edge_ctrl #(
   parameter int   CNT_W         = 16,
   parameter int   STABLE_CYCLES = 1000,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,       // asynchronous, active low
   input  logic       raw_in,
   output logic       data_out,
   output logic       enable_out,
   output logic       rise,
   output logic       fall,
   output logic       busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      CHK_HI    = 2'b01,
      STABLE_HI = 2'b10,
      CHK_LO    = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam state_t           RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             data_q, data_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Synchronizer next values: raw_in is read here and nowhere else.
   always_comb begin
      s1_d = raw_in;
      s2_d = s1_q;
   end

   // Qualification FSM: a departure from the stable level starts a count;
   // any sample back at the stable level abandons it without a pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s2_q) begin
               state_d = CHK_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         CHK_HI: begin
            if (!s2_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               data_d  = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2_q) begin
               state_d = CHK_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         CHK_LO: begin
            if (s2_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               data_d  = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RST_STATE;
            cnt_d   = '0;
         end
      endcase
   end

   // State register; reset aborts any qualification in progress at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q    <= RESET_LEVEL;
         s2_q    <= RESET_LEVEL;
         state_q <= RST_STATE;
         cnt_q   <= '0;
         data_q  <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Outputs come straight from registers so they are glitch-free.
   always_comb begin
      data_out   = data_q;
      rise       = rise_q;
      fall       = fall_q;
      enable_out = rise_q | fall_q;
      busy       = (state_q == CHK_HI) || (state_q == CHK_LO);
      state_dbg  = state_q;
   end

endmodule

// File: tb/tb_debounce_edge_ctrl.sv
// Bench for debounce_edge_ctrl with STABLE_CYCLES=4, RESET_LEVEL=0.
`timescale 1ns/1ps
module tb_debounce_edge_ctrl;

   localparam int S = 4;

   logic       clk;
   logic       reset;
   logic       raw_in;
   logic       data_out, enable_out, rise, fall, busy;
   logic [1:0] state_dbg;
   logic       dff_q;

   int n_tests = 0;
   int n_fail  = 0;

   debounce_edge_ctrl #(.CNT_W(16), .STABLE_CYCLES(S), .RESET_LEVEL(1'b0)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .data_out(data_out), .enable_out(enable_out), .rise(rise), .fall(fall),
      .busy(busy), .state_dbg(state_dbg)
   );

   // Downstream enable-gated register fed by the debouncer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dff_q <= 1'b0;
      else if (enable_out) dff_q <= data_out;
   end

   // Clock: 2 ns period.
   initial clk = 1'b0;
   always #1 clk = ~clk;

   // Reference model: the observed sample at an edge is the raw level captured
   // two edges earlier; a level is accepted once the last S observations all
   // differ from the current debounced level.
   logic m_p1, m_p2, m_level, m_rise, m_fall, m_busy, m_dff;
   logic m_hist[$];

   task automatic model_reset();
      m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_dff = 1'b0;
      m_hist.delete();
   endtask

   task automatic model_edge(input logic r);
      logic obs;
      int   k;
      obs = m_p2;
      m_p2 = m_p1;
      m_p1 = r;
      if (m_rise || m_fall) m_dff = m_level;
      m_hist.push_back(obs);
      if (m_hist.size() > S) void'(m_hist.pop_front());
      k = 0;
      for (int i = m_hist.size() - 1; i >= 0; i--) begin
         if (m_hist[i] != m_level) k++;
         else break;
      end
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (k == S) begin
         m_level = obs;
         m_rise  = obs;
         m_fall  = !obs;
         m_busy  = 1'b0;
      end else begin
         m_busy  = (k > 0);
      end
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_vs_model();
      check("data_out", data_out, m_level);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("enable_out", enable_out, m_rise | m_fall);
      check("busy", busy, m_busy);
      check("dff_q", dff_q, m_dff);
      check("rise_and_fall", rise & fall, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, data_out, 1'b0);
      check({tag, "_rise"}, rise, 1'b0);
      check({tag, "_fall"}, fall, 1'b0);
      check({tag, "_en"}, enable_out, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   // One clock: drive raw at the falling edge, let the rising edge sample it,
   // then compare at the next falling edge.
   task automatic drive_cycle(input logic r);
      raw_in = r;
      @(posedge clk);
      model_edge(r);
      @(negedge clk);
      check_all_vs_model();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic async_reset_pulse(input string tag);
      #0.3;
      reset = 1'b0;
      #0.2;
      check_all_zero(tag);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_all_zero({tag, "_held"});
      reset = 1'b1;
   endtask

   typedef struct {
      logic raw;
      logic data;
      logic rise;
      logic fall;
      logic busy;
   } vec_t;

   vec_t tbl[14];
   int   edge_idx;
   int   n_rise, n_fall;

   initial begin
      // Clean rise then a 3-edge low glitch that must be rejected.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      // Test 1: reset held with raw_in toggling.
      reset  = 1'b0;
      raw_in = 1'b1;
      model_reset();
      #0.5;
      check_all_zero("reset_async");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         raw_in = ~raw_in;
         check_all_zero("reset_hold");
         check("reset_dff", dff_q, 1'b0);
      end
      raw_in = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Test 2/3: table-driven clean rise and rejected low glitch.
      for (int i = 0; i < 14; i++) begin
         drive_cycle(tbl[i].raw);
         check($sformatf("tbl%0d_data", i), data_out, tbl[i].data);
         check($sformatf("tbl%0d_rise", i), rise, tbl[i].rise);
         check($sformatf("tbl%0d_fall", i), fall, tbl[i].fall);
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("tbl%0d_en", i), enable_out, tbl[i].rise | tbl[i].fall);
      end

      // Test 4: bounce from data_out=1: 1,0,1,0,0,... -> one fall at index 8.
      begin
         logic seq[10];
         int   fall_at;
         seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         fall_at = -1; n_rise = 0; n_fall = 0;
         for (int i = 0; i < 10; i++) begin
            drive_cycle(seq[i]);
            if (fall) begin n_fall++; fall_at = i; end
            if (rise) n_rise++;
         end
         check("bounce_fall_once", n_fall == 1, 1'b1);
         check("bounce_fall_pos", fall_at == 8, 1'b1);
         check("bounce_no_rise", n_rise == 0, 1'b1);
         check("bounce_data", data_out, 1'b0);
      end

      // Test 3b: raw high for exactly 4 edges is accepted.
      n_rise = 0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1);
         if (rise) n_rise++;
      end
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0);
         if (rise) n_rise++;
      end
      check("glitch4_accepted", n_rise == 1, 1'b1);
      for (int i = 0; i < 6; i++) drive_cycle(1'b0);

      // Test 5: reset after 2 qualifying edges, then re-qualify from low.
      for (int i = 0; i < 4; i++) drive_cycle(1'b1);
      check("midchk_busy_before", busy, 1'b1);
      async_reset_pulse("midchk");
      edge_idx = -1;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1);
         if (rise && edge_idx < 0) edge_idx = i;
      end
      check("midchk_rise_pos", edge_idx == 5, 1'b1);
      for (int i = 0; i < 6; i++) drive_cycle(1'b0);

      // Random runs of 1..6 edges, with an occasional asynchronous reset.
      for (int r = 0; r < 400; r++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) drive_cycle(lvl);
         if ($urandom_range(0, 60) == 0) async_reset_pulse("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
